// File: rtl/join_digits_if.sv
// Keypad-to-setpoint digit entry bus.
//   master : keypad side, drives digit_valid/digit/enter/clear and observes results
//   slave  : join_digits side, consumes the strobes and drives value/value_valid/
//            digit_err/entry_count/busy
interface join_digits_if;
  logic       digit_valid;
  logic [3:0] digit;
  logic       enter;
  logic       clear;
  logic [7:0] value;
  logic       value_valid;
  logic       digit_err;
  logic [1:0] entry_count;
  logic       busy;

  modport master (
    output digit_valid, digit, enter, clear,
    input  value, value_valid, digit_err, entry_count, busy
  );

  modport slave (
    input  digit_valid, digit, enter, clear,
    output value, value_valid, digit_err, entry_count, busy
  );
endinterface

// File: rtl/join_digits.sv
// join_digits: accumulates decimal digits (last two kept) and, on enter,
// rebuilds the binary value tens*10 + ones (0..99) over two busy cycles.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : join_digits_if.slave
//         in : digit_valid, digit[3:0], enter, clear
//         out: value[7:0], value_valid, digit_err, entry_count[1:0], busy
module join_digits #(
  parameter int unsigned MAX_DIGITS = 2
) (
  input  logic          clk,
  input  logic          rst,
  join_digits_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ONE,
    S_TWO,
    S_CALC1,
    S_CALC2
  } state_t;

  state_t     state_q;
  logic [3:0] tens_q;
  logic [3:0] ones_q;
  logic [7:0] t10_q;
  logic [7:0] value_q;
  logic       value_valid_q;
  logic       digit_err_q;
  logic [1:0] cnt_q;
  logic       busy_q;

  logic       digit_legal;
  logic [3:0] tens_d;
  logic [3:0] ones_d;
  logic [1:0] cnt_d;

  assign digit_legal = (bus.digit <= 4'd9);

  // Digits after absorbing this cycle's strobe; enter then acts on these,
  // so a digit and enter in the same cycle commit the new digit.
  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    cnt_d  = cnt_q;
    if (bus.digit_valid && digit_legal) begin
      if (state_q == S_IDLE) begin
        tens_d = '0;
        ones_d = bus.digit;
        cnt_d  = 2'd1;
      end else begin
        tens_d = ones_q;
        ones_d = bus.digit;
        cnt_d  = 2'd2;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      tens_q        <= '0;
      ones_q        <= '0;
      t10_q         <= '0;
      value_q       <= '0;
      value_valid_q <= 1'b0;
      digit_err_q   <= 1'b0;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
    end else begin
      value_valid_q <= 1'b0;
      digit_err_q   <= 1'b0;
      case (state_q)
        S_IDLE, S_ONE, S_TWO: begin
          if (bus.clear) begin
            state_q <= S_IDLE;
            tens_q  <= '0;
            ones_q  <= '0;
            cnt_q   <= '0;
          end else begin
            digit_err_q <= bus.digit_valid && !digit_legal;
            tens_q      <= tens_d;
            ones_q      <= ones_d;
            cnt_q       <= cnt_d;
            if (bus.enter && (cnt_d != 2'd0)) begin
              state_q <= S_CALC1;
              busy_q  <= 1'b1;
            end else begin
              state_q <= (cnt_d == 2'd0) ? S_IDLE :
                         (cnt_d == 2'd1) ? S_ONE  : S_TWO;
            end
          end
        end
        S_CALC1: begin
          // tens*10 as shift-add: tens*8 + tens*2
          t10_q   <= {1'b0, tens_q, 3'b000} + {3'b000, tens_q, 1'b0};
          state_q <= S_CALC2;
        end
        S_CALC2: begin
          value_q       <= t10_q + {4'b0000, ones_q};
          value_valid_q <= 1'b1;
          tens_q        <= '0;
          ones_q        <= '0;
          cnt_q         <= '0;
          busy_q        <= 1'b0;
          state_q       <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.value       = value_q;
  assign bus.value_valid = value_valid_q;
  assign bus.digit_err   = digit_err_q;
  assign bus.entry_count = cnt_q;
  assign bus.busy        = busy_q;

endmodule
